multi_channel_capture_ip: RTL and testbench
===========================================

// Module: multi_channel_capture_ip
// PURPOSE
//  Parametrised successor of the single-channel test IP. Merges N_CH independent
//  valid/ready input streams into one registered output stream tagged with a channel ID.
//  - Each channel has its own FIFO; a round-robin arbiter with burst-hold selects the source.
//  - Provides a sticky protocol-error flag on test_output.
//  - Sits directly under the top-level wrapper as the design under SDC promotion.
// PARAMETERS
//  N_CH       4   number of input channels (2..16)
//  DATA_W     8   data width per channel
//  DEPTH      4   per-channel FIFO depth, power of 2, >=2
//  BURST_LEN  2   max consecutive grants to one channel before rotating (>=1)
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            async active-low reset
//  in_data      in   N_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
//  in_valid     in   N_CH         per-channel valid
//  in_ready     out  N_CH         per-channel ready (= FIFO not full)
//  out_data     out  DATA_W       registered output data
//  out_chan     out  CH_W         source channel of out_data, CH_W=$clog2(N_CH)
//  out_valid    out  1            registered output valid
//  out_ready    in   1            downstream ready
//  err_clear    in   1            synchronous clear of test_output
//  test_output  out  1            sticky protocol-error flag
// BEHAVIOUR
//  - Reset (async, rst_n=0): all FIFOs empty; in_ready = all 1s; out_valid=0, out_data=0,
//    out_chan=0, test_output=0; rr pointer=N_CH-1 (ch0 wins first); burst count=0.
//  - Input accept: beat on channel c when in_valid[c] & in_ready[c] at a rising edge.
//    in_ready[c] depends only on FIFO c occupancy, never on in_valid.
//  - Output stage: loads when (!out_valid | out_ready) and any FIFO non-empty; pops the winner.
//    If nothing is eligible and out_ready=1, out_valid drops to 0.
//    out_data/out_chan hold stable while out_valid & !out_ready.
//  - Latency: beat accepted at edge k appears on out_* after edge k+1 (1 cycle), if granted.
//  - Arbitration:
//    - If the last-granted channel is still non-empty and burst count < BURST_LEN, grant it again.
//    - Otherwise grant the first non-empty channel after the rr pointer, wrapping N_CH-1 -> 0.
//    - On a grant to a different channel: burst count := 1, rr pointer := that channel.
//    - On a repeat grant: count++.
//  - Simultaneous push and pop on the same FIFO: both occur; occupancy is unchanged.
//    A pop is allowed on a full FIFO while in_ready=0.
//  - FIFO pointers are DEPTH-wrapping with an extra wrap bit for full/empty.
//    Full: in_ready=0. Empty: channel ineligible.
//  - Protocol error: set test_output when, for any c, in_valid[c]=1 & in_ready[c]=0 in cycle t
//    and in_valid[c]=0 in cycle t+1 (valid withdrawn).
//    Set takes priority over err_clear in the same cycle.
//  - Reset mid-operation discards all buffered beats; no output beat is emitted after reset.
// CONFIGURATION
//  MCIP_PARITY_EN defined:
//    - adds output port out_parity (1 bit) = ^{out_chan,out_data} (even parity);
//    - registered with out_data; reset value 0.
//  MCIP_PARITY_EN undefined: port and logic are absent; all other behaviour is identical.
// STRUCTURE
//  - Package mcip_pkg: typedef chan_id_t (CH_W bits), function clog2 helper,
//    localparam defaults for N_CH/DATA_W/DEPTH/BURST_LEN.
//  - Sub-module mcip_chan_fifo (DATA_W, DEPTH): push/pop/full/empty/dout.
//    Instantiated N_CH times via generate.
//  - Arbiter, burst counter, output register and error flag live in the top module.
// TESTING
//  1. Reset: hold rst_n=0 with in_valid all 1s -> in_ready=4'hF, out_valid=0, test_output=0.
//  2. Single beat: ch2 sends 8'hA5 at edge k, out_ready=1
//     -> after k+1: out_valid=1, out_data=8'hA5, out_chan=2; after k+2: out_valid=0.
//  3. Burst round-robin: ch0 and ch1 each preload 4 beats (0x10..0x13, 0x20..0x23),
//     out_ready=1 -> out_chan sequence 0,0,1,1,0,0,1,1 with data in per-channel order.
//  4. Backpressure/full: out_ready=0, ch3 pushes 5 beats -> in_ready[3]=0 after the 4th;
//     out_* stable; releasing out_ready drains 4 beats, then the 5th is accepted.
//  5. Protocol error: ch1 full, in_valid[1] 1->0 while in_ready[1]=0 -> test_output=1;
//     pulse err_clear -> 0.
//     Repeat with the violation in the same cycle as err_clear -> test_output stays 1.
//  6. Reset mid-stream: rst_n low while 3 beats are buffered -> out_valid=0 immediately;
//     after release, no stale beats appear.

Source files
------------

// File: rtl/mcip_pkg.sv
// -----------------------------------------------------------------------------
// mcip_pkg
// Shared definitions for the multi-channel capture IP.
//   - Default parameter values for the top module.
//   - clog2 helper, usable in constant expressions.
//   - chan_id_t: channel identifier type for the default channel count.
// -----------------------------------------------------------------------------
package mcip_pkg;

    localparam int N_CH_DEF      = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int DEPTH_DEF     = 4;
    localparam int BURST_LEN_DEF = 2;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int CH_W_DEF = clog2(N_CH_DEF);

    typedef logic [CH_W_DEF-1:0] chan_id_t;

endpackage

// File: rtl/mcip_chan_fifo.sv
// -----------------------------------------------------------------------------
// mcip_chan_fifo
// Single-clock per-channel FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
// A push while full or a pop while empty is ignored. Push and pop in the same
// cycle both take effect.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   async active-low reset (empties the FIFO)
//   i_push   in   write i_din this cycle (ignored when full)
//   i_din    in   DATA_W write data
//   i_pop    in   advance read pointer this cycle (ignored when empty)
//   o_dout   out  DATA_W head-of-queue data (combinational read)
//   o_full   out  FIFO holds DEPTH entries
//   o_empty  out  FIFO holds no entries
// -----------------------------------------------------------------------------
module mcip_chan_fifo
    import mcip_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_full,
    output logic              o_empty
);

    localparam int AW = clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop  & ~o_empty;
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage is not reset: the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

endmodule

// File: rtl/multi_channel_capture_ip.sv
// -----------------------------------------------------------------------------
// multi_channel_capture_ip
// Merges N_CH valid/ready input streams into one registered output stream
// tagged with the source channel. Each channel is buffered by its own FIFO;
// a round-robin arbiter with burst-hold picks the source for the output
// register. A sticky flag reports any channel that withdraws valid while it
// was being back-pressured.
//
// Optional feature: define MCIP_PARITY_EN to add out_parity, an even-parity
// bit over {out_chan, out_data} registered together with the data.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   async active-low reset
//   in_data      in   N_CH*DATA_W, channel c at [c*DATA_W +: DATA_W]
//   in_valid     in   N_CH per-channel valid
//   in_ready     out  N_CH per-channel ready (FIFO not full)
//   out_data     out  DATA_W registered output data
//   out_chan     out  CH_W source channel of out_data
//   out_valid    out  registered output valid
//   out_ready    in   downstream ready
//   err_clear    in   synchronous clear of test_output
//   test_output  out  sticky protocol-error flag
//   out_parity   out  (MCIP_PARITY_EN only) ^{out_chan, out_data}
// -----------------------------------------------------------------------------
module multi_channel_capture_ip
    import mcip_pkg::*;
#(
    parameter int N_CH      = N_CH_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    localparam int CH_W     = (N_CH > 1) ? clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [CH_W-1:0]        out_chan,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef MCIP_PARITY_EN
    output logic                   out_parity,
`endif
    input  logic                   err_clear,
    output logic                   test_output
);

    localparam int BW = clog2(BURST_LEN + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_LEN);

    logic [N_CH-1:0]   w_full;
    logic [N_CH-1:0]   w_empty;
    logic [N_CH-1:0]   w_push;
    logic [N_CH-1:0]   w_pop;
    logic [DATA_W-1:0] w_dout [N_CH];

    logic [CH_W-1:0]   w_grant;
    logic              w_any;
    logic              w_load;
    logic              w_err_set;

    logic [CH_W-1:0]   r_rr;
    logic [BW-1:0]     r_burst;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_chan;
    logic              r_err;
    logic [N_CH-1:0]   r_stall_prev;

    // ---------------------------------------------------------------- FIFOs
    genvar c;
    generate
        for (c = 0; c < N_CH; c++) begin : g_chan
            assign w_push[c] = in_valid[c] & ~w_full[c];

            mcip_chan_fifo #(
                .DATA_W (DATA_W),
                .DEPTH  (DEPTH)
            ) u_fifo (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_push  (w_push[c]),
                .i_din   (in_data[c*DATA_W +: DATA_W]),
                .i_pop   (w_pop[c]),
                .o_dout  (w_dout[c]),
                .o_full  (w_full[c]),
                .o_empty (w_empty[c])
            );
        end
    endgenerate

    // Ready is purely a function of FIFO occupancy, never of in_valid.
    assign in_ready = ~w_full;

    // ------------------------------------------------------------- Arbiter
    // r_burst == 0 only after reset and means "no previous grant", so the
    // hold rule cannot lock onto the reset value of r_rr; ch0 wins first.
    always_comb begin
        int              j;
        logic [CH_W-1:0] idx;
        logic            found;
        w_grant = r_rr;
        w_any   = |(~w_empty);
        found   = 1'b0;
        j       = 0;
        idx     = '0;
        if ((r_burst != '0) && (r_burst < BURST_MAX) && !w_empty[r_rr]) begin
            w_grant = r_rr;
        end else begin
            // Scan starts just after the pointer; the pointer itself is
            // visited last so a lone busy channel keeps being served.
            for (int i = 1; i <= N_CH; i++) begin
                j = int'(r_rr) + i;
                if (j >= N_CH) begin
                    j = j - N_CH;
                end
                idx = CH_W'(j);
                if (!found && !w_empty[idx]) begin
                    found   = 1'b1;
                    w_grant = idx;
                end
            end
        end
    end

    assign w_load = (~r_out_valid | out_ready) & w_any;
    assign w_pop  = w_load ? (N_CH'(1) << w_grant) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr    <= CH_W'(N_CH - 1);
            r_burst <= '0;
        end else if (w_load) begin
            r_rr <= w_grant;
            if ((w_grant == r_rr) && (r_burst != '0)) begin
                // Saturate: beyond BURST_LEN the channel is only re-served
                // through the rotation scan when nobody else is waiting.
                if (r_burst < BURST_MAX) begin
                    r_burst <= r_burst + 1'b1;
                end
            end else begin
                r_burst <= BW'(1);
            end
        end
    end

    // ------------------------------------------------------ Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_dout[w_grant];
            r_out_chan  <= w_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

`ifdef MCIP_PARITY_EN
    logic r_out_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_parity <= 1'b0;
        end else if (w_load) begin
            r_out_parity <= ^{w_grant, w_dout[w_grant]};
        end
    end

    assign out_parity = r_out_parity;
`endif

    // ---------------------------------------------------------- Error flag
    // A channel stalled last cycle (valid & !ready) that drops valid now has
    // withdrawn a beat. Setting wins over a simultaneous clear.
    assign w_err_set = |(r_stall_prev & ~in_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_prev <= '0;
            r_err        <= 1'b0;
        end else begin
            r_stall_prev <= in_valid & w_full;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clear) begin
                r_err <= 1'b0;
            end
        end
    end

    assign test_output = r_err;

endmodule

// File: tb/tb_multi_channel_capture_ip.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_capture_ip
// Directed bench for multi_channel_capture_ip (default parameters). Expected
// output beats are queued in the order the arbitration rules dictate and
// compared as the DUT hands them downstream.
// -----------------------------------------------------------------------------
module tb_multi_channel_capture_ip;
    import mcip_pkg::*;

    localparam int N_CH   = 4;
    localparam int DATA_W = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH*DATA_W-1:0] in_data;
    logic [N_CH-1:0]        in_valid;
    logic [N_CH-1:0]        in_ready;
    logic [DATA_W-1:0]      out_data;
    logic [1:0]             out_chan;
    logic                   out_valid;
    logic                   out_ready;
    logic                   err_clear;
    logic                   test_output;
`ifdef MCIP_PARITY_EN
    logic                   out_parity;
`endif

    typedef struct packed {
        chan_id_t          ch;
        logic [DATA_W-1:0] d;
    } beat_t;

    beat_t sb_q[$];
    beat_t mon_b;
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    multi_channel_capture_ip dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef MCIP_PARITY_EN
        .out_parity  (out_parity),
`endif
        .err_clear   (err_clear),
        .test_output (test_output)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input int ch, input logic [DATA_W-1:0] d);
        beat_t b;
        b.ch = chan_id_t'(ch);
        b.d  = d;
        sb_q.push_back(b);
    endtask

    // Present one beat on channel ch and hold it until accepted (bounded).
    task automatic send(input int ch, input logic [DATA_W-1:0] d);
        int n;
        n = 0;
        in_data[ch*DATA_W +: DATA_W] = d;
        in_valid[ch] = 1'b1;
        @(negedge clk);
        while (!in_ready[ch] && n < 64) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready[ch]) begin
            check("send_timeout", {31'd0, in_ready[ch]}, 32'd1);
        end
        @(posedge clk);
        #1;
        in_valid[ch] = 1'b0;
    endtask

    // Output monitor: a beat is consumed at the edge following a mid-cycle
    // sample of out_valid & out_ready.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected: observed chan=%0d data=%0h expected=no beat", out_chan, out_data);
            end
            if (sb_q.size() != 0) begin
                mon_b = sb_q.pop_front();
                check("sb_chan", {30'd0, out_chan}, {30'd0, mon_b.ch});
                check("sb_data", {24'd0, out_data}, {24'd0, mon_b.d});
`ifdef MCIP_PARITY_EN
                check("sb_parity", {31'd0, out_parity}, {31'd0, ^{mon_b.ch, mon_b.d}});
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Reset with valids asserted
        rst_n     = 1'b0;
        in_valid  = '1;
        in_data   = '0;
        out_ready = 1'b0;
        err_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",    {28'd0, in_ready}, 32'hF);
        check("rst_out_valid",   {31'd0, out_valid}, 32'd0);
        check("rst_out_data",    {24'd0, out_data}, 32'd0);
        check("rst_out_chan",    {30'd0, out_chan}, 32'd0);
        check("rst_test_output", {31'd0, test_output}, 32'd0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, one-cycle latency
        out_ready = 1'b1;
        expect_beat(2, 8'hA5);
        send(2, 8'hA5);
        @(posedge clk);
        #1;
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_data",  {24'd0, out_data}, 32'hA5);
        check("single_chan",  {30'd0, out_chan}, 32'd2);
        @(posedge clk);
        #1;
        check("single_drop",  {31'd0, out_valid}, 32'd0);

        // Burst round-robin between ch0 and ch1
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data[7:0]   = 8'(8'h10 + i);
            in_data[15:8]  = 8'(8'h20 + i);
            in_valid[1:0]  = 2'b11;
            @(negedge clk);
            check("rr_ready", {30'd0, in_ready[1:0]}, 32'd3);
            @(posedge clk);
            #1;
        end
        in_valid = '0;
        expect_beat(0, 8'h10); expect_beat(0, 8'h11);
        expect_beat(1, 8'h20); expect_beat(1, 8'h21);
        expect_beat(0, 8'h12); expect_beat(0, 8'h13);
        expect_beat(1, 8'h22); expect_beat(1, 8'h23);
        check("rr_stall_chan", {30'd0, out_chan}, 32'd0);
        check("rr_stall_data", {24'd0, out_data}, 32'h10);
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("rr_drained", sb_q.size(), 32'd0);
        check("rr_idle",    {31'd0, out_valid}, 32'd0);

        // Backpressure: output register stalled, ch3 fills its FIFO
        out_ready = 1'b0;
        expect_beat(0, 8'h30);
        send(0, 8'h30);
        @(posedge clk);
        #1;
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            expect_beat(3, 8'(8'h40 + i));
            send(3, 8'(8'h40 + i));
        end
        check("bp_full", {31'd0, in_ready[3]}, 32'd0);
        expect_beat(3, 8'h44);
        in_data[31:24] = 8'h44;
        in_valid[3]    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_still_full",  {31'd0, in_ready[3]}, 32'd0);
        check("bp_stable_vld",  {31'd0, out_valid}, 32'd1);
        check("bp_stable_data", {24'd0, out_data}, 32'h30);
        check("bp_stable_chan", {30'd0, out_chan}, 32'd0);
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready[3] && n < 64) begin
            n++;
            @(negedge clk);
        end
        check("bp_5th_ready", {31'd0, in_ready[3]}, 32'd1);
        @(posedge clk);
        #1;
        in_valid[3] = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("bp_drained", sb_q.size(), 32'd0);
        check("bp_no_err",  {31'd0, test_output}, 32'd0);

        // Protocol error: withdraw valid on a full ch1
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_beat(1, 8'(8'h50 + i));
            send(1, 8'(8'h50 + i));
        end
        check("pe_full", {31'd0, in_ready[1]}, 32'd0);
        in_data[15:8] = 8'h55;
        in_valid[1]   = 1'b1;
        @(posedge clk);
        #1;
        check("pe_no_err_yet", {31'd0, test_output}, 32'd0);
        in_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        check("pe_set", {31'd0, test_output}, 32'd1);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        check("pe_clear", {31'd0, test_output}, 32'd0);
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        err_clear   = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        check("pe_set_over_clear", {31'd0, test_output}, 32'd1);
        err_clear = 1'b1;
        @(posedge clk);
        #1;
        err_clear = 1'b0;
        check("pe_clear2", {31'd0, test_output}, 32'd0);
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("pe_drained", sb_q.size(), 32'd0);

        // Reset mid-stream discards buffered beats
        out_ready = 1'b0;
        send(2, 8'h60);
        send(2, 8'h61);
        send(2, 8'h62);
        @(posedge clk);
        #1;
        check("mr_pre_valid", {31'd0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_valid",    {31'd0, out_valid}, 32'd0);
        check("mr_in_ready", {28'd0, in_ready}, 32'hF);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("mr_no_stale", {31'd0, out_valid}, 32'd0);
        check("mr_sb_empty", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
